// File: rtl/lsu_pkg.sv
// Shared constants and decode helpers for the load/store unit.
package lsu_pkg;

    localparam int XLEN      = 64;
    localparam int MEM_DEPTH = 256;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACCESS   = 2'd1;
    localparam logic [1:0] ST_MERGE_WR = 2'd2;
    localparam logic [1:0] ST_RESP     = 2'd3;

    // One bit per byte lane touched by an access of this size, starting at lane 0.
    function automatic logic [7:0] byte_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] funct3, input logic [2:0] offset);
        case (funct3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return offset[0] == 1'b0;
            2'b10:   return offset[1:0] == 2'b00;
            default: return offset == 3'b000;
        endcase
    endfunction

    function automatic logic is_legal(input logic load, input logic store, input logic [2:0] funct3);
        if (load == store)
            return 1'b0;
        else if (load)
            return funct3 != 3'b111;
        else
            return funct3[2] == 1'b0;
    endfunction

    function automatic logic in_range(input logic [XLEN-1:0] addr, input int depth);
        return addr[XLEN-1:3] < (XLEN-3)'(depth);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response channel plus the data-memory port of the load/store unit.
interface load_store_unit_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_load;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;

    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_write_data;
    logic [XLEN-1:0] mem_read_data;

    // Environment view: core requester plus the data memory.
    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data
    );

    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract with sign/zero extension, and sub-word store merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      offset,
    input  logic [XLEN-1:0] mem_word,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged_word
);

    logic [5:0]      shamt;
    logic [XLEN-1:0] lanes;
    logic [XLEN-1:0] lane_mask;
    logic [7:0]      bmask;

    assign shamt = {offset, 3'b000};

    always_comb begin
        lanes     = mem_word >> shamt;
        load_data = lanes;
        case (funct3[1:0])
            2'b00:   load_data = funct3[2] ? {56'd0, lanes[7:0]}  : {{56{lanes[7]}},  lanes[7:0]};
            2'b01:   load_data = funct3[2] ? {48'd0, lanes[15:0]} : {{48{lanes[15]}}, lanes[15:0]};
            2'b10:   load_data = funct3[2] ? {32'd0, lanes[31:0]} : {{32{lanes[31]}}, lanes[31:0]};
            default: load_data = lanes;
        endcase
    end

    always_comb begin
        bmask     = byte_mask(funct3);
        lane_mask = '0;
        for (int i = 0; i < 8; i++)
            lane_mask[i*8 +: 8] = {8{bmask[i]}};
        lane_mask   = lane_mask << shamt;
        merged_word = (mem_word & ~lane_mask) | ((store_data << shamt) & lane_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit top: request FSM, response registers and data-memory port drive.
//   state    | meaning
//   IDLE     | ready for a request; decode and fault check at accept
//   ACCESS   | memory cycle: load read, SD write, or read half of a sub-word store
//   MERGE_WR | write back the merged word for SB/SH/SW
//   RESP     | one-cycle completion pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = lsu_pkg::MEM_DEPTH
)
(
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);

    logic [1:0]      state;
    logic            op_load;
    logic [2:0]      op_funct3;
    logic [XLEN-1:0] op_addr;
    logic [XLEN-1:0] op_wdata;
    logic [XLEN-1:0] merged_q;
    logic [XLEN-1:0] rdata_q;
    logic            fault_q;

    logic            accept;
    logic            req_fault;
    logic            in_access;
    logic            in_merge;
    logic            is_sd;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged_word;

    assign accept    = bus.req_valid && bus.req_ready;
    assign req_fault = !is_legal(bus.req_load, bus.req_store, bus.req_funct3)
                    || !is_aligned(bus.req_funct3, bus.req_addr[2:0])
                    || !in_range(bus.req_addr, MEM_DEPTH);

    // Memory strobes are gated by reset so an interrupted operation never writes.
    assign in_access = (state == ST_ACCESS) && !reset;
    assign in_merge  = (state == ST_MERGE_WR) && !reset;
    assign is_sd     = !op_load && (op_funct3 == F3_D);

    assign bus.req_ready      = (state == ST_IDLE) && !reset;
    assign bus.resp_valid     = (state == ST_RESP) && !reset;
    assign bus.resp_rdata     = rdata_q;
    assign bus.resp_fault     = fault_q;
    assign bus.mem_read       = in_access && !is_sd;
    assign bus.mem_write      = (in_access && is_sd) || in_merge;
    assign bus.mem_address    = (in_access || in_merge) ? {3'b000, op_addr[XLEN-1:3]} : '0;
    assign bus.mem_write_data = in_merge ? merged_q : ((in_access && is_sd) ? op_wdata : '0);

    lsu_align u_align (
        .funct3      (op_funct3),
        .offset      (op_addr[2:0]),
        .mem_word    (bus.mem_read_data),
        .store_data  (op_wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_load   <= 1'b0;
            op_funct3 <= '0;
            op_addr   <= '0;
            op_wdata  <= '0;
            merged_q  <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_load   <= bus.req_load;
                        op_funct3 <= bus.req_funct3;
                        op_addr   <= bus.req_addr;
                        op_wdata  <= bus.req_wdata;
                        fault_q   <= req_fault;
                        rdata_q   <= '0;
                        state     <= req_fault ? ST_RESP : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (op_load) begin
                        rdata_q <= load_data;
                        state   <= ST_RESP;
                    end else if (is_sd) begin
                        state   <= ST_RESP;
                    end else begin
                        merged_q <= merged_word;
                        state    <= ST_MERGE_WR;
                    end
                end
                ST_MERGE_WR: state <= ST_RESP;
                default:     state <= ST_IDLE;
            endcase
        end
    end

endmodule
